// File: rtl/mem_port_arbiter.sv
// Two-master arbiter (instruction fetch, data access) onto one single-port
// memory bus. One transfer outstanding at a time; data access wins ties.
// Optional build macro ARB_STARVE_GUARD_EN adds a starvation guard that hands
// a tied request to the fetch side after STARVE_MAX consecutive data grants
// made while a fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  // instruction fetch port
  input  logic                  IF_Req,
  input  logic [ADDR_W-1:0]     IF_Addr,
  output logic [DATA_W-1:0]     IF_RData,
  output logic                  IF_Done,
  output logic                  IF_Stall,
  // data access port
  input  logic                  DM_Req,
  input  logic                  DM_We,
  input  logic [ADDR_W-1:0]     DM_Addr,
  input  logic [DATA_W-1:0]     DM_WData,
  input  logic [DATA_W/8-1:0]   DM_BE,
  output logic [DATA_W-1:0]     DM_RData,
  output logic                  DM_Done,
  output logic                  DM_Stall,
  // memory bus
  output logic                  Bus_Req,
  output logic                  Bus_We,
  output logic [ADDR_W-1:0]     Bus_Addr,
  output logic [DATA_W-1:0]     Bus_WData,
  output logic [DATA_W/8-1:0]   Bus_BE,
  input  logic [DATA_W-1:0]     Bus_RData,
  input  logic                  Bus_Ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2
  } state_t;

  state_t state;
  state_t state_n;
  logic   grant_if;
  logic   grant_dm;
  logic   xfer_done;
  logic   if_first;

  // A zero starvation limit would make the guard meaningless.
  if (STARVE_MAX == 0) begin : g_cfg_check
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Fetch takes a tie once data has won STARVE_MAX times in a row over it.
  assign if_first = (starve_cnt == CNT_W'(STARVE_MAX));

  // Count consecutive data grants made while a fetch was waiting.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm) begin
      if (IF_Req) starve_cnt <= starve_cnt + CNT_W'(1);
      else        starve_cnt <= '0;
    end
  end
`else
  assign if_first = 1'b0;
`endif

  // Stalls drop in the Done cycle so the requester can advance immediately.
  assign IF_Stall = IF_Req && !IF_Done;
  assign DM_Stall = DM_Req && !DM_Done;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Arbitration and transfer-completion decode.
  always_comb begin
    state_n   = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    xfer_done = 1'b0;
    case (state)
      IDLE: begin
        if (DM_Req && !(IF_Req && if_first)) begin
          grant_dm = 1'b1;
          state_n  = SERVE_DM;
        end else if (IF_Req) begin
          grant_if = 1'b1;
          state_n  = SERVE_IF;
        end
      end
      SERVE_IF, SERVE_DM: begin
        if (Bus_Ready) begin
          xfer_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus request launch, read-data capture and Done pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Bus_Req   <= 1'b0;
      Bus_We    <= 1'b0;
      Bus_Addr  <= '0;
      Bus_WData <= '0;
      Bus_BE    <= '0;
      IF_RData  <= '0;
      DM_RData  <= '0;
      IF_Done   <= 1'b0;
      DM_Done   <= 1'b0;
    end else begin
      IF_Done <= 1'b0;
      DM_Done <= 1'b0;
      if (grant_dm) begin
        Bus_Req   <= 1'b1;
        Bus_We    <= DM_We;
        Bus_Addr  <= DM_Addr;
        Bus_WData <= DM_WData;
        Bus_BE    <= DM_BE;
      end else if (grant_if) begin
        Bus_Req   <= 1'b1;
        Bus_We    <= 1'b0;
        Bus_Addr  <= IF_Addr;
        Bus_WData <= '0;
        Bus_BE    <= '1;
      end else if (xfer_done) begin
        Bus_Req <= 1'b0;
        if (state == SERVE_IF) begin
          IF_RData <= Bus_RData;
          IF_Done  <= 1'b1;
        end else begin
          DM_Done <= 1'b1;
          if (!Bus_We) DM_RData <= Bus_RData;
        end
      end
    end
  end

endmodule
